// File: rtl/mux_seq_pkg.sv
// Shared types and helpers for the mux_seq_stream serializer.
// State encoding and the constant clog2 used to size the word index.
package mux_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_STREAM = 2'd1,
      ST_DONE   = 2'd2
   } state_t;

   function automatic int mux_seq_clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

endpackage

// File: rtl/mux_seq_stream_mux_n_1.sv
// Purely combinational N:1 word selector over a flattened bus.
// Any select value with no matching word returns zero.
module mux_n_1
   import mux_seq_pkg::*;
#(
   parameter  int DATA_W = 16,
   parameter  int N_IN   = 18,
   localparam int SEL_W  = mux_seq_clog2(N_IN)
) (
   input  logic [N_IN*DATA_W-1:0] i_data,
   input  logic [SEL_W-1:0]       i_sel,
   output logic [DATA_W-1:0]      o_data
);

   always_comb begin
      o_data = '0;
      for (int unsigned k = 0; k < N_IN; k++) begin
         if (i_sel == SEL_W'(k)) begin
            o_data = i_data[k*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/mux_seq_stream.sv
// Snapshots an N_IN-word vector on start and streams it out over valid/ready.
// Optional macro MUXSEQ_RAND_EN adds a registered random-read port (rd_sel/rd_data).
module mux_seq_stream
   import mux_seq_pkg::*;
#(
   parameter  int DATA_W = 16,
   parameter  int N_IN   = 18,
   localparam int IDX_W  = mux_seq_clog2(N_IN)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [N_IN*DATA_W-1:0] in_data,
   output logic                   busy,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DATA_W-1:0]      out_data,
   output logic [IDX_W-1:0]       out_idx,
   output logic                   out_last,
   output logic                   done
`ifdef MUXSEQ_RAND_EN
   ,
   input  logic [IDX_W-1:0]       rd_sel,
   output logic [DATA_W-1:0]      rd_data
`endif
);

   state_t                  r_state;
   state_t                  w_next_state;
   logic [N_IN*DATA_W-1:0]  r_bank;
   logic [IDX_W-1:0]        r_idx;
   logic                    w_fire;
   logic                    w_is_last;
   logic                    w_capture;
   logic [DATA_W-1:0]       w_stream_word;

   assign w_is_last = (r_idx == IDX_W'(N_IN - 1));
   assign w_fire    = out_valid & out_ready;
   assign w_capture = (r_state == ST_IDLE) & start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:   if (start) w_next_state = ST_STREAM;
         ST_STREAM: if (w_fire && w_is_last) w_next_state = ST_DONE;
         ST_DONE:   w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      out_valid = (r_state == ST_STREAM);
      busy      = (r_state == ST_STREAM) || (r_state == ST_DONE);
      done      = (r_state == ST_DONE);
      out_last  = (r_state == ST_STREAM) && w_is_last;
   end

   // idx runs one past the last word after the final beat; the selector maps that to zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bank <= '0;
         r_idx  <= '0;
      end else if (w_capture) begin
         r_bank <= in_data;
         r_idx  <= '0;
      end else if (w_fire) begin
         r_idx  <= r_idx + IDX_W'(1);
      end
   end

   mux_n_1 #(
      .DATA_W (DATA_W),
      .N_IN   (N_IN)
   ) u_stream_mux (
      .i_data (r_bank),
      .i_sel  (r_idx),
      .o_data (w_stream_word)
   );

   assign out_data = w_stream_word;
   assign out_idx  = r_idx;

`ifdef MUXSEQ_RAND_EN
   logic [DATA_W-1:0] w_rd_word;
   logic [DATA_W-1:0] r_rd_data;

   mux_n_1 #(
      .DATA_W (DATA_W),
      .N_IN   (N_IN)
   ) u_rand_mux (
      .i_data (r_bank),
      .i_sel  (rd_sel),
      .o_data (w_rd_word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= w_rd_word;
      end
   end

   assign rd_data = r_rd_data;
`endif

endmodule
